rename_free_list: RTL and testbench

- Register-rename back end that supplies the out-of-order issue buffer with physical register tags and the 64-entry `ready_list` vector. The buffer samples `ready_list` to mark queued instructions ready.
- Holds the architectural-to-physical map table, a FIFO of free physical registers, a FIFO of superseded mappings (old pregs), and 4 branch checkpoints.
- Consumes the buffer's retire and mispredict-recover outputs, plus writeback tags from the execute stage.

---
 rtl/rename_free_list.sv | 166 ++++++++++++++++
 tb/tb_rename_free_list.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rename_free_list.sv
// Register-rename back end: arch->phys map table, free-tag FIFO, superseded-tag FIFO,
// branch checkpoints and the per-tag ready vector for the issue buffer.
module rename_free_list #(
  parameter int unsigned PHYS_REGS   = 64,
  parameter int unsigned ARCH_REGS   = 32,
  parameter int unsigned CHECKPOINTS = 4,
  parameter int unsigned OLD_DEPTH   = 8,
  localparam int unsigned PW = $clog2(PHYS_REGS),
  localparam int unsigned AW = $clog2(ARCH_REGS),
  localparam int unsigned CW = $clog2(CHECKPOINTS),
  localparam int unsigned OW = $clog2(OLD_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic                 alloc_uses_rw,
  input  logic [AW-1:0]        alloc_rw,
  input  logic [AW-1:0]        alloc_rs,
  input  logic [AW-1:0]        alloc_rt,
  input  logic                 alloc_is_branch,
  output logic [PW-1:0]        rs_preg,
  output logic [PW-1:0]        rt_preg,
  output logic [PW-1:0]        rw_preg,
  output logic                 alloc_stall,
  input  logic                 wb_valid,
  input  logic [PW-1:0]        wb_preg,
  input  logic                 retired,
  input  logic                 retired_uses_rw,
  input  logic                 branch_retired,
  input  logic                 recover,
  input  logic [CW-1:0]        recover_entry,
  output logic [PHYS_REGS-1:0] ready_list
);

  localparam logic [PW:0] FreeInc  = 1;
  localparam logic [OW:0] OldInc   = 1;
  localparam logic [CW:0] CkptInc  = 1;
  localparam logic [OW:0] OldFull  = (OW+1)'(OLD_DEPTH);
  localparam logic [CW:0] CkptFull = (CW+1)'(CHECKPOINTS);

  logic [PW-1:0] map_q [ARCH_REGS];
  logic [PW-1:0] map_d [ARCH_REGS];
  logic [PW-1:0] free_mem_q [PHYS_REGS];
  logic [PW-1:0] free_mem_d [PHYS_REGS];
  logic [PW:0]   free_head_q, free_head_d, free_tail_q, free_tail_d, free_count;
  logic [PW-1:0] old_mem_q [OLD_DEPTH];
  logic [PW-1:0] old_mem_d [OLD_DEPTH];
  logic [OW:0]   old_head_q, old_head_d, old_tail_q, old_tail_d, old_count;
  logic [PW-1:0] ckpt_map_q [CHECKPOINTS][ARCH_REGS];
  logic [PW-1:0] ckpt_map_d [CHECKPOINTS][ARCH_REGS];
  logic [PW:0]   ckpt_free_head_q [CHECKPOINTS];
  logic [PW:0]   ckpt_free_head_d [CHECKPOINTS];
  logic [OW:0]   ckpt_old_tail_q [CHECKPOINTS];
  logic [OW:0]   ckpt_old_tail_d [CHECKPOINTS];
  logic [CW:0]   ckpt_head_q, ckpt_head_d, ckpt_tail_q, ckpt_tail_d, ckpt_count;
  logic [PHYS_REGS-1:0] ready_q, ready_d;

  logic eff_rw, do_alloc, do_ckpt, do_retire;

  assign free_count = free_tail_q - free_head_q;
  assign old_count  = old_tail_q - old_head_q;
  assign ckpt_count = ckpt_tail_q - ckpt_head_q;

  assign eff_rw      = alloc_valid & alloc_uses_rw & (alloc_rw != '0);
  assign alloc_stall = alloc_valid & ((eff_rw & ((free_count == '0) | (old_count == OldFull))) |
                                      (alloc_is_branch & (ckpt_count == CkptFull)));
  assign do_alloc    = eff_rw & ~alloc_stall & ~recover;
  assign do_ckpt     = alloc_valid & alloc_is_branch & ~alloc_stall & ~recover;
  assign do_retire   = retired & retired_uses_rw & (old_count != '0);

  assign rs_preg    = map_q[alloc_rs];
  assign rt_preg    = map_q[alloc_rt];
  assign rw_preg    = free_mem_q[free_head_q[PW-1:0]];
  assign ready_list = ready_q;

  always_comb begin
    map_d            = map_q;
    free_mem_d       = free_mem_q;
    free_head_d      = free_head_q;
    free_tail_d      = free_tail_q;
    old_mem_d        = old_mem_q;
    old_head_d       = old_head_q;
    old_tail_d       = old_tail_q;
    ckpt_map_d       = ckpt_map_q;
    ckpt_free_head_d = ckpt_free_head_q;
    ckpt_old_tail_d  = ckpt_old_tail_q;
    ckpt_head_d      = ckpt_head_q;
    ckpt_tail_d      = ckpt_tail_q;
    ready_d          = ready_q;

    if (do_alloc) begin
      map_d[alloc_rw]                 = rw_preg;
      free_head_d                     = free_head_q + FreeInc;
      old_mem_d[old_tail_q[OW-1:0]]   = map_q[alloc_rw];
      old_tail_d                      = old_tail_q + OldInc;
    end

    // The free tail is never checkpointed, so retirement proceeds even during recovery.
    if (do_retire) begin
      free_mem_d[free_tail_q[PW-1:0]] = old_mem_q[old_head_q[OW-1:0]];
      free_tail_d                     = free_tail_q + FreeInc;
      old_head_d                      = old_head_q + OldInc;
    end

    if (do_ckpt) begin
      ckpt_map_d[ckpt_tail_q[CW-1:0]]       = map_d;
      ckpt_free_head_d[ckpt_tail_q[CW-1:0]] = free_head_d;
      ckpt_old_tail_d[ckpt_tail_q[CW-1:0]]  = old_tail_d;
      ckpt_tail_d                           = ckpt_tail_q + CkptInc;
    end

    if (branch_retired) begin
      ckpt_head_d = ckpt_head_q + CkptInc;
    end

    // Restored tail keeps the MSB consistent: slots head..recover_entry remain outstanding.
    if (recover) begin
      map_d       = ckpt_map_q[recover_entry];
      free_head_d = ckpt_free_head_q[recover_entry];
      old_tail_d  = ckpt_old_tail_q[recover_entry];
      ckpt_tail_d = ckpt_head_q + {1'b0, recover_entry - ckpt_head_q[CW-1:0]} + CkptInc;
    end

    if (wb_valid && (wb_preg != '0)) begin
      ready_d[wb_preg] = 1'b1;
    end
    if (do_alloc) begin
      ready_d[rw_preg] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
      for (int i = 0; i < PHYS_REGS; i++) free_mem_q[i] <= PW'(i + ARCH_REGS);
      for (int i = 0; i < OLD_DEPTH; i++) old_mem_q[i] <= '0;
      for (int c = 0; c < CHECKPOINTS; c++) begin
        for (int a = 0; a < ARCH_REGS; a++) ckpt_map_q[c][a] <= '0;
        ckpt_free_head_q[c] <= '0;
        ckpt_old_tail_q[c]  <= '0;
      end
      for (int p = 0; p < PHYS_REGS; p++) ready_q[p] <= (p < ARCH_REGS);
      free_head_q <= '0;
      free_tail_q <= (PW+1)'(ARCH_REGS);
      old_head_q  <= '0;
      old_tail_q  <= '0;
      ckpt_head_q <= '0;
      ckpt_tail_q <= '0;
    end else begin
      map_q            <= map_d;
      free_mem_q       <= free_mem_d;
      free_head_q      <= free_head_d;
      free_tail_q      <= free_tail_d;
      old_mem_q        <= old_mem_d;
      old_head_q       <= old_head_d;
      old_tail_q       <= old_tail_d;
      ckpt_map_q       <= ckpt_map_d;
      ckpt_free_head_q <= ckpt_free_head_d;
      ckpt_old_tail_q  <= ckpt_old_tail_d;
      ckpt_head_q      <= ckpt_head_d;
      ckpt_tail_q      <= ckpt_tail_d;
      ready_q          <= ready_d;
    end
  end

endmodule

// File: tb/tb_rename_free_list.sv
// Scoreboard bench for rename_free_list: an in-order instruction window model predicts
// tags, stalls and ready bits; a monitor compares them against the DUT each cycle.
module tb_rename_free_list;

  localparam int OldDepth = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_valid = 1'b0, alloc_uses_rw = 1'b0, alloc_is_branch = 1'b0;
  logic [4:0] alloc_rw = '0, alloc_rs = '0, alloc_rt = '0;
  logic [5:0] rs_preg, rt_preg, rw_preg;
  logic       alloc_stall;
  logic       wb_valid = 1'b0;
  logic [5:0] wb_preg = '0;
  logic       retired = 1'b0, retired_uses_rw = 1'b0, branch_retired = 1'b0, recover = 1'b0;
  logic [1:0] recover_entry = '0;
  logic [63:0] ready_list;

  always #5 clk = ~clk;

  rename_free_list dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_uses_rw(alloc_uses_rw), .alloc_rw(alloc_rw),
    .alloc_rs(alloc_rs), .alloc_rt(alloc_rt), .alloc_is_branch(alloc_is_branch),
    .rs_preg(rs_preg), .rt_preg(rt_preg), .rw_preg(rw_preg), .alloc_stall(alloc_stall),
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .retired(retired), .retired_uses_rw(retired_uses_rw), .branch_retired(branch_retired),
    .recover(recover), .recover_entry(recover_entry), .ready_list(ready_list)
  );

  typedef struct {
    int seq; bit has_rw; int rw; int new_tag; int old_tag; bit is_br;
  } rob_t;
  typedef struct { int seq; int slot; } ck_t;
  typedef struct {
    bit stall; bit chk_p; int rs; int rt; bit chk_rw; int rw; logic [63:0] ready;
  } exp_t;

  // Reference model: map, ready bits, free/superseded tag lists and the in-flight window.
  int          map [32];
  logic [63:0] ready;
  int          free_q[$], old_q[$];
  rob_t        rob[$];
  ck_t         ckq[$];
  int          ck_base, seq_n;
  exp_t        exp_q[$];

  int n_checks = 0, n_fail = 0;

  bit s_rst, s_av, s_urw, s_br, s_wbv, s_ret;
  int s_rw, s_rs, s_rt, s_wbp, s_rec;

  function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) map[i] = i;
    ready = {32'h0, 32'hFFFF_FFFF};
    free_q.delete();
    for (int i = 32; i < 64; i++) free_q.push_back(i);
    old_q.delete(); rob.delete(); ckq.delete();
    ck_base = 0;
  endfunction

  task automatic idle();
    s_rst = 0; s_av = 0; s_urw = 0; s_br = 0; s_wbv = 0; s_ret = 0;
    s_rw = 0; s_rs = 0; s_rt = 0; s_wbp = 0; s_rec = -1;
  endtask

  task automatic alloc(int rw, int rs, int rt, bit br);
    idle();
    s_av = 1; s_urw = 1; s_rw = rw; s_rs = rs; s_rt = rt; s_br = br;
  endtask

  task automatic tick();
    exp_t e; rob_t r;
    bit eff, stall, head_br, ret_rw, rec_ok, wbv;
    int tgt;
    @(negedge clk);
    if (s_rst) begin
      rst = 1'b1;
      alloc_valid = 0; alloc_uses_rw = 0; alloc_is_branch = 0; wb_valid = 0;
      retired = 0; retired_uses_rw = 0; branch_retired = 0; recover = 0;
      model_reset();
      e = '{stall: 0, chk_p: 0, rs: 0, rt: 0, chk_rw: 1, rw: free_q[0], ready: ready};
      exp_q.push_back(e);
      return;
    end
    rst = 1'b0;
    head_br = s_ret && rob.size() > 0 && rob[0].is_br;
    ret_rw  = (rob.size() > 0) ? rob[0].has_rw : 1'b1;
    rec_ok  = s_rec >= 0 && s_rec < ckq.size() && !head_br;
    eff     = s_av && s_urw && s_rw != 0;
    stall   = s_av && ((eff && (free_q.size() == 0 || old_q.size() == OldDepth)) ||
                       (s_br && ckq.size() == 4));
    wbv     = s_wbv && !(free_q.size() > 0 && s_wbp == free_q[0]);

    alloc_valid = s_av; alloc_uses_rw = s_urw; alloc_is_branch = s_br;
    alloc_rw = 5'(s_rw); alloc_rs = 5'(s_rs); alloc_rt = 5'(s_rt);
    wb_valid = wbv; wb_preg = 6'(s_wbp);
    retired = s_ret; retired_uses_rw = s_ret && ret_rw; branch_retired = head_br;
    recover = rec_ok; recover_entry = rec_ok ? 2'(ckq[s_rec].slot) : 2'd0;

    e.stall = stall; e.chk_p = s_av; e.rs = map[s_rs]; e.rt = map[s_rt];
    e.chk_rw = free_q.size() > 0; e.rw = e.chk_rw ? free_q[0] : 0; e.ready = ready;
    exp_q.push_back(e);

    if (s_ret && rob.size() > 0) begin
      r = rob.pop_front();
      if (r.has_rw) free_q.push_back(old_q.pop_front());
      if (r.is_br) begin void'(ckq.pop_front()); ck_base++; end
    end
    if (rec_ok) begin
      tgt = ckq[s_rec].seq;
      while (rob.size() > 0 && rob[rob.size()-1].seq > tgt) begin
        r = rob.pop_back();
        if (r.has_rw) begin
          map[r.rw] = r.old_tag;
          free_q.push_front(r.new_tag);
          void'(old_q.pop_back());
        end
      end
      while (ckq.size() > s_rec + 1) void'(ckq.pop_back());
    end
    if (wbv && s_wbp != 0) ready[s_wbp] = 1'b1;
    if (s_av && !stall && !rec_ok) begin
      r = '{seq: seq_n, has_rw: eff, rw: s_rw, new_tag: 0, old_tag: 0, is_br: s_br};
      seq_n++;
      if (eff) begin
        r.new_tag = free_q.pop_front();
        r.old_tag = map[s_rw];
        map[s_rw] = r.new_tag;
        old_q.push_back(r.old_tag);
        ready[r.new_tag] = 1'b0;
      end
      if (s_br) ckq.push_back('{seq: r.seq, slot: (ck_base + ckq.size()) % 4});
      rob.push_back(r);
    end
  endtask

  task automatic do_reset();
    idle(); s_rst = 1; tick(); idle();
  endtask

  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        check("alloc_stall", 64'(alloc_stall), 64'(m.stall));
        if (m.chk_p) begin
          check("rs_preg", 64'(rs_preg), 64'(m.rs));
          check("rt_preg", 64'(rt_preg), 64'(m.rt));
        end
        if (m.chk_rw) check("rw_preg", 64'(rw_preg), 64'(m.rw));
        check("ready_list", ready_list, m.ready);
      end
    end
  end

  initial begin : stimulus
    seq_n = 0;
    model_reset();
    do_reset();
    tick();

    // Retire with an empty superseded FIFO, then two renames of r5 and a lookup of r5.
    s_ret = 1; tick();
    alloc(5, 5, 0, 0); tick();
    alloc(5, 5, 5, 0); tick();
    idle(); s_av = 1; s_rs = 5; s_rt = 5; tick();
    idle(); s_wbv = 1; s_wbp = 33; tick();
    idle(); s_wbv = 1; s_wbp = 0; tick();
    idle(); s_ret = 1; tick(); tick();
    idle(); tick();

    // Fill the superseded FIFO until rename stalls, then release with a retire.
    do_reset();
    for (int i = 0; i < 10; i++) begin alloc(i + 1, i + 1, 9, 0); tick(); end
    alloc(9, 9, 1, 0); s_ret = 1; tick();
    alloc(9, 9, 1, 0); tick();
    idle(); s_av = 1; s_rs = 9; tick();

    // Checkpoint on the second rename, two younger renames, then recover to it.
    do_reset();
    alloc(1, 0, 0, 0); tick();
    alloc(2, 2, 0, 1); tick();
    alloc(7, 7, 0, 0); tick();
    alloc(8, 8, 7, 0); tick();
    idle(); s_rec = 0; tick();
    alloc(7, 7, 8, 0); tick();
    idle(); s_av = 1; s_rs = 2; s_rt = 7; tick();

    // Exhaust checkpoints (rw=0 never renames), free one, reuse slot 0, recover to it.
    do_reset();
    for (int i = 0; i < 5; i++) begin alloc(0, 0, 0, 1); tick(); end
    alloc(0, 0, 0, 1); s_ret = 1; tick();
    alloc(0, 0, 0, 1); tick();
    alloc(3, 3, 0, 0); tick();
    idle(); s_rec = 3; tick();
    alloc(3, 3, 0, 0); tick();

    // Randomized traffic with periodic asynchronous resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      idle();
      if (c % 997 == 500) s_rst = 1;
      s_av  = $urandom_range(0, 9) < 7;
      s_urw = $urandom_range(0, 4) != 0;
      s_rw  = $urandom_range(0, 31);
      s_rs  = $urandom_range(0, 31);
      s_rt  = $urandom_range(0, 31);
      s_br  = $urandom_range(0, 4) == 0;
      s_ret = $urandom_range(0, 9) < 4;
      s_wbv = $urandom_range(0, 9) < 4;
      if (rob.size() > 0 && $urandom_range(0, 1) == 1)
        s_wbp = rob[$urandom_range(0, rob.size() - 1)].new_tag;
      else
        s_wbp = $urandom_range(0, 63);
      if (ckq.size() > 0 && $urandom_range(0, 19) == 0) s_rec = $urandom_range(0, ckq.size() - 1);
      tick();
    end

    idle(); tick(); tick();
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
